// File: rtl/bin_to_gray_counter.sv
// Up/down binary counter with a registered Gray-code view of the same count.
// The binary and Gray registers load on the same edge from one next-state
// value, so the two outputs never disagree. A one-cycle wrap pulse marks
// all-ones -> zero (counting up) and zero -> all-ones (counting down).
// A synchronous load overrides counting and never produces a wrap pulse.
//
// Control handshake: there is no valid/ready pair. The counter acts on
// every rising edge. load and en are sampled on that edge, and the result
// appears on binary/gray/wrap after the edge, which is one clock of latency.
module bin_to_gray_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] binary,
    output logic [WIDTH-1:0] gray,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO     = '0;
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_q;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_q;
    logic             wrap_d;
    logic             at_max;
    logic             at_min;

    assign at_max = (bin_q == ALL_ONES);
    assign at_min = (bin_q == ZERO);

    // Next binary value: load wins over stepping, and stepping wins over hold.
    always_comb begin
        bin_d = bin_q;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (up) begin
                bin_d = bin_q + ONE;
            end else begin
                bin_d = bin_q - ONE;
            end
        end
    end

    // Wrap fires only for an enabled step that crosses the end of the range.
    always_comb begin
        wrap_d = 1'b0;
        if (!load && en) begin
            wrap_d = up ? at_max : at_min;
        end
    end

    // The Gray code comes from the next binary value, so it lands with bin_q.
    always_comb begin
        gray_d = bin_d ^ (bin_d >> 1);
    end

    // State registers. Reset clears everything at once, including a live wrap pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign binary = bin_q;
    assign gray   = gray_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_bin_to_gray_counter.sv
// Self-checking bench for bin_to_gray_counter at WIDTH=4.
module tb_bin_to_gray_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up;
  logic         load;
  logic [W-1:0] load_bin;
  logic [W-1:0] binary;
  logic [W-1:0] gray;
  logic         wrap;

  int n_checks;
  int n_fail;

  // reference model state: plain integers
  int exp_bin;
  int exp_wrap;

  bin_to_gray_counter #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .binary   (binary),
    .gray     (gray),
    .wrap     (wrap)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Gray code built by reflection: successive codes differ in one bit,
  // and the upper half mirrors the lower half with the top bit set.
  function automatic int gray_of(input int b);
    int g;
    int half;
    g = 0;
    half = MOD / 2;
    for (int lvl = W - 1; lvl >= 0; lvl--) begin
      if (b >= (1 << lvl)) begin
        g = g + (1 << lvl);
        b = (2 << lvl) - 1 - b;
      end
    end
    return g;
  endfunction

  // model update for one rising edge using the currently driven inputs
  task automatic model_edge();
    if (rst) begin
      exp_bin  = 0;
      exp_wrap = 0;
    end else if (load) begin
      exp_bin  = int'(load_bin);
      exp_wrap = 0;
    end else if (en) begin
      if (up) begin
        exp_wrap = (exp_bin == MOD - 1) ? 1 : 0;
        exp_bin  = (exp_bin + 1) % MOD;
      end else begin
        exp_wrap = (exp_bin == 0) ? 1 : 0;
        exp_bin  = (exp_bin + MOD - 1) % MOD;
      end
    end else begin
      exp_wrap = 0;
    end
  endtask

  // driver: one clock, inputs held from the previous negedge, ends on negedge
  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic u, input logic l, input logic [W-1:0] lb);
    en = e;
    up = u;
    load = l;
    load_bin = lb;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 4'b1011);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (binary !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: binary=%b gray=%b wrap=%b, required 0000/0000/0", i, binary, gray, wrap);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
    rst = 1'b0;
    exp_bin = 0;
    exp_wrap = 0;
  endtask

  task automatic test_full_up();
    logic [W-1:0] table_g [16];
    logic [W-1:0] prev_g;
    table_g = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
                4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
    prev_g = gray;
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (gray !== table_g[i] || wrap !== ((i == 15) ? 1'b1 : 1'b0) || binary !== W'((i + 1) % MOD)) begin
        n_fail++;
        $display("FAIL full_up[%0d]: gray=%b wrap=%b binary=%b, required %b/%b/%0d",
                 i, gray, wrap, binary, table_g[i], (i == 15), (i + 1) % MOD);
      end
      n_checks++;
      if ($countones(gray ^ prev_g) != 1) begin
        n_fail++;
        $display("FAIL full_up_onebit[%0d]: %b -> %b, required one-bit change", i, prev_g, gray);
      end
      prev_g = gray;
    end
  endtask

  task automatic test_load_priority();
    drive(1'b1, 1'b1, 1'b1, 4'b1010);
    tick();
    n_checks++;
    if (binary !== 4'b1010 || gray !== 4'b1111 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL load_priority: binary=%b gray=%b wrap=%b, required 1010/1111/0", binary, gray, wrap);
    end
    // set up all-ones, then load together with an up-step that would wrap
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    tick();
    drive(1'b1, 1'b1, 1'b1, 4'b0110);
    tick();
    n_checks++;
    if (binary !== 4'b0110 || gray !== 4'b0101 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL load_no_wrap: binary=%b gray=%b wrap=%b, required 0110/0101/0", binary, gray, wrap);
    end
  endtask

  task automatic test_down_wrap();
    drive(1'b0, 1'b0, 1'b1, 4'b0000);
    tick();
    drive(1'b1, 1'b0, 1'b0, 4'b0000);
    tick();
    n_checks++;
    if (binary !== 4'b1111 || gray !== 4'b1000 || wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: binary=%b gray=%b wrap=%b, required 1111/1000/1", binary, gray, wrap);
    end
    tick();
    n_checks++;
    if (binary !== 4'b1110 || gray !== 4'b1001 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL down_after_wrap: binary=%b gray=%b wrap=%b, required 1110/1001/0", binary, gray, wrap);
    end
  endtask

  task automatic test_hold();
    drive(1'b0, 1'b1, 1'b1, 4'b0101);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'b1111);
    for (int i = 0; i < 5; i++) begin
      up = 1'(i);
      tick();
      n_checks++;
      if (binary !== 4'b0101 || gray !== 4'b0111 || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL hold[%0d]: binary=%b gray=%b wrap=%b, required 0101/0111/0", i, binary, gray, wrap);
      end
    end
  endtask

  task automatic test_async_reset();
    // mid-count reset
    drive(1'b0, 1'b1, 1'b1, 4'b0100);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    n_checks++;
    if (gray !== 4'b0110) begin
      n_fail++;
      $display("FAIL async_setup: gray=%b, required 0110", gray);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (binary !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: binary=%b gray=%b wrap=%b, required 0000/0000/0 before edge", binary, gray, wrap);
    end
    tick();
    rst = 1'b0;
    tick();
    n_checks++;
    if (binary !== 4'b0001 || gray !== 4'b0001) begin
      n_fail++;
      $display("FAIL restart1: binary=%b gray=%b, required 0001/0001", binary, gray);
    end
    tick();
    n_checks++;
    if (binary !== 4'b0010 || gray !== 4'b0011) begin
      n_fail++;
      $display("FAIL restart2: binary=%b gray=%b, required 0010/0011", binary, gray);
    end
    // reset landing on a live wrap pulse
    drive(1'b0, 1'b1, 1'b1, 4'b1111);
    tick();
    drive(1'b1, 1'b1, 1'b0, 4'b0000);
    tick();
    drive(1'b0, 1'b1, 1'b0, 4'b0000);
    n_checks++;
    if (wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_before_rst: wrap=%b, required 1", wrap);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (wrap !== 1'b0 || binary !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_cleared_by_rst: wrap=%b binary=%b, required 0/0000", wrap, binary);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] prev_g;
    logic         stepped;
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 9) == 0), W'($urandom_range(0, MOD - 1)));
      prev_g = gray;
      stepped = en && !load;
      tick();
      n_checks++;
      if (binary !== W'(exp_bin) || gray !== W'(gray_of(exp_bin)) || wrap !== 1'(exp_wrap)) begin
        n_fail++;
        $display("FAIL random[%0d]: binary=%b gray=%b wrap=%b, required %b/%b/%0d",
                 i, binary, gray, wrap, W'(exp_bin), W'(gray_of(exp_bin)), exp_wrap);
      end
      if (stepped) begin
        n_checks++;
        if ($countones(gray ^ prev_g) != 1) begin
          n_fail++;
          $display("FAIL random_onebit[%0d]: %b -> %b, required one-bit change", i, prev_g, gray);
        end
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    exp_bin = 0;
    exp_wrap = 0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    test_reset();
    test_full_up();
    test_load_priority();
    test_down_wrap();
    test_hold();
    test_async_reset();
    exp_bin = 0;
    exp_wrap = 0;
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bin_to_gray_counter.md
BIN_TO_GRAY_COUNTER -- requirements
Module: bin_to_gray_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter and code width in bits, legal range 2..16.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have port en, input, 1 bit: advance the count by one step on this clock edge.
REQ-005 SHALL have port up, input, 1 bit: step direction; 1 = increment, 0 = decrement; sampled only when en=1.
REQ-006 SHALL have port load, input, 1 bit: synchronous load of load_bin.
REQ-007 SHALL have port load_bin, input, WIDTH bits: binary value to load.
REQ-008 SHALL have port binary, output, WIDTH bits: registered binary count.
REQ-009 SHALL have port gray, output, WIDTH bits: registered Gray encoding of binary.
REQ-010 SHALL have port wrap, output, 1 bit: one-cycle pulse marking a counter wrap-around.

Function
REQ-011 SHALL hold an internal binary count register bin_q, driven directly onto binary.
REQ-012 SHALL compute the next binary value bin_d with priority load > en > hold:
- load=1: bin_d = load_bin.
- en=1 and up=1: bin_d = bin_q+1 mod 2^WIDTH.
- en=1 and up=0: bin_d = bin_q-1 mod 2^WIDTH.
- otherwise: bin_d = bin_q.
REQ-013 SHALL register gray as bin_d XOR (bin_d >> 1) on the same edge as bin_q, so that gray always encodes binary with zero cycles of skew.
REQ-014 SHALL produce gray as a registered output with no combinational path from any input to gray.
REQ-015 SHALL update binary and gray one cycle after the edge that samples load or en, giving a latency of 1 clock.
REQ-016 SHALL assert wrap for exactly the cycle following an enabled up-step from all-ones to zero, or an enabled down-step from zero to all-ones.
REQ-017 SHALL keep wrap at 0 on every load cycle, including when load=1 and en=1 occur together and en alone would have wrapped.
REQ-018 SHALL change exactly one bit of gray on every enabled step in either direction, including across a wrap.
REQ-019 SHALL take the direction from the current up value on each enabled step; a direction reversal takes effect on the first edge where it is sampled.
REQ-020 SHALL, when load=1 and en=1 in the same cycle, take load_bin exactly; en and up are ignored for that cycle.
REQ-021 SHALL, when en=0 and load=0, hold binary and gray unchanged and drive wrap to 0.

Reset
REQ-022 SHALL force bin_q, gray and wrap to 0 immediately when rst asserts, without waiting for a clock edge.
REQ-023 SHALL ignore en and load while rst=1.
REQ-024 SHALL resume counting from 0 on the first rising edge after rst deasserts.
REQ-025 SHALL clear a wrap pulse that is in progress when rst asserts mid-operation, in the same instant.

Verification (WIDTH=4)
REQ-026 SHALL check reset: rst=1 with en=1 and load=1 -> binary=0000, gray=0000, wrap=0 throughout reset.
REQ-027 SHALL check a full up-count: en=1, up=1 for 16 edges from 0 -> gray follows 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000, each step a one-bit change, with wrap=1 only alongside the final 0000.
REQ-028 SHALL check load priority: load=1, load_bin=1010 with en=1, up=1 -> next cycle binary=1010, gray=1111, wrap=0.
REQ-029 SHALL check a down-wrap: count at 0, en=1, up=0 -> binary=1111, gray=1000, wrap=1 for one cycle; the next down-step gives binary=1110, gray=1001, wrap=0.
REQ-030 SHALL check hold: count at 0101 (gray 0111), en=0 and load=0 for 5 edges -> outputs unchanged, wrap=0.
REQ-031 SHALL check asynchronous reset mid-count: gray=0110, rst pulsed between clock edges -> binary and gray read 0000 before the next edge, and counting restarts 0001, 0011, ... after release.
